cmd_dispatcher: RTL and testbench
=================================

Name: cmd_dispatcher

Overview:
- Downstream consumer of the 80-bit EBI command FIFO.
- Pops one command at a time and holds it until its scheduled start time on a local free-running timebase.
- Then presents it to the pin-controller bus with a req/ack handshake.
- Handles local timebase commands itself and reports handshake timeouts.

Parameters:
- ACK_TIMEOUT, 255: max cycles bus_req may stay high without bus_ack before the command is dropped.
- TIME_PRESCALE, 1: clk cycles per timebase tick; minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cmd_fifo_data_out  in  80  command word from FIFO; valid the cycle after cmd_fifo_rd_en (standard, non-FWFT)
- cmd_fifo_empty  in  1  FIFO empty flag
- cmd_fifo_rd_en  out  1  FIFO pop, single-cycle pulse
- bus_addr  out  8  target controller id
- bus_op  out  8  opcode
- bus_data  out  32  payload
- bus_req  out  1  request, held until ack or timeout
- bus_ack  in  1  target acceptance
- current_time  out  32  timebase value
- busy  out  1  high whenever state is not IDLE
- cmd_timeout  out  1  one-cycle pulse when a command is dropped

Behaviour:
- Command fields:
  - [79:72] addr
  - [71:64] op
  - [63:32] start_time
  - [31:0] data
  - [79:64] is the first EBI word written.
- Reset: all outputs 0; state IDLE; timebase 0; prescaler 0; timeout counter 0. Reset mid-handshake drops bus_req on the next edge; the in-flight command is lost.
- Timebase:
  - current_time increments by 1 every TIME_PRESCALE clk cycles and wraps 0xFFFFFFFF -> 0.
  - A local reset command sets current_time and the prescaler to 0 on the edge it executes; that edge's increment is overridden.
- FSM states: IDLE, LATCH, WAIT_TIME, WAIT_ACK.
  - IDLE: if !cmd_fifo_empty, assert cmd_fifo_rd_en combinationally and go to LATCH; otherwise stay.
  - LATCH: register the 80-bit word into the internal command register; go to WAIT_TIME.
  - WAIT_TIME: due when bit 31 of (current_time - start_time) is 0. This is wrap-safe for offsets < 2^31; start_time = 0 right after a local reset is due immediately.
    - Not due: stay.
    - Due, addr == 8'hFF (local): op 8'h01 resets the timebase, all other ops are a NOP; go to IDLE, no bus activity.
    - Due, other addr: drive bus_addr/op/data, set bus_req = 1 on that edge, clear the timeout counter, go to WAIT_ACK.
  - WAIT_ACK: bus_addr/op/data and bus_req are stable.
    - bus_ack sampled high: bus_req = 0 on that edge, go to IDLE.
    - Else the timeout counter increments; when it reaches ACK_TIMEOUT-1 without ack: bus_req = 0, cmd_timeout pulses 1 cycle, go to IDLE.
    - Ack and timeout on the same cycle: ack wins, no timeout pulse.
- bus_ack outside WAIT_ACK is ignored.
- Latency for an immediate command from an empty-to-nonempty FIFO:
  - rd_en in cycle 0
  - latch in cycle 1
  - WAIT_TIME evaluates in cycle 2
  - bus_req high in cycle 3
- Throughput: at most one command in flight. Minimum 4 cycles per bus command with same-cycle ack; 3 cycles per local command.
- bus_addr/op/data keep their last value after completion; they are don't-care while bus_req = 0.
- The FIFO is never popped while empty, and never popped outside IDLE.

Decomposition:
- Shared package:
  - field offsets and widths (ADDR_HI/LO, OP_HI/LO, TIME_HI/LO, DATA_HI/LO)
  - LOCAL_ADDR = 8'hFF
  - OP_RESET_TIME = 8'h01
  - FSM state encoding
  - Also used by the EBI software-side header generator.
- One sub-module: cmd_timebase, containing the prescaler, the 32-bit counter and the sync clear input.

Test Plan:
- Reset while in WAIT_ACK with bus_req = 1 -> next edge bus_req = 0, busy = 0, current_time = 0, cmd_fifo_rd_en = 0.
- FIFO holds {FF,01,00000000,0} after current_time reaches 500 -> current_time = 0 the cycle after WAIT_TIME; no bus_req ever.
- Single command {03,02,00000000,DEADBEEF}, bus_ack tied 1 -> rd_en at cycle 0, bus_req high at cycle 3 with addr = 03, op = 02, data = DEADBEEF; low at cycle 4; busy low at cycle 4.
- Command start_time = 1000 pushed at time 10 (TIME_PRESCALE = 1) -> bus_req rises exactly when current_time == 1000; same command with start_time = 5 issues immediately.
- Wrap: preload via time reset, run to 0xFFFFFFF0, start_time = 0x00000005 -> stays in WAIT_TIME across the wrap, issues at current_time == 5.
- bus_ack never asserted, ACK_TIMEOUT = 8 -> bus_req high exactly 8 cycles, one cmd_timeout pulse, next queued command is then popped.

Source files
------------

// File: rtl/cmd_dispatcher_pkg.sv
// -----------------------------------------------------------------------------
// cmd_dispatcher_pkg
//   Shared definitions for the command dispatcher.
//   - Bit layout of the 80-bit EBI command word (addr | op | start_time | data).
//   - Local address and local opcodes handled inside the dispatcher.
//   - Dispatcher FSM state encoding.
//   - Wrap-safe "is it time yet" helper on the 32-bit timebase.
//   The EBI software-side header generator reads the same constants, so field
//   positions here must only change together with the host software.
// -----------------------------------------------------------------------------
package cmd_dispatcher_pkg;

  // Command word layout; [79:64] is the first EBI word written by the host.
  localparam int unsigned CMD_W   = 80;
  localparam int unsigned ADDR_HI = 79;
  localparam int unsigned ADDR_LO = 72;
  localparam int unsigned OP_HI   = 71;
  localparam int unsigned OP_LO   = 64;
  localparam int unsigned TIME_HI = 63;
  localparam int unsigned TIME_LO = 32;
  localparam int unsigned DATA_HI = 31;
  localparam int unsigned DATA_LO = 0;

  // Commands addressed here never reach the pin-controller bus.
  localparam logic [7:0] LOCAL_ADDR    = 8'hFF;
  localparam logic [7:0] OP_RESET_TIME = 8'h01;

  typedef enum logic [1:0] {
    StIdle,
    StLatch,
    StWaitTime,
    StWaitAck
  } disp_state_e;

  // Due once now has reached or passed start. The subtraction wraps, so the
  // comparison stays correct across the 0xFFFFFFFF -> 0 rollover as long as the
  // scheduled time lies less than 2^31 ticks away.
  function automatic logic time_due(input logic [31:0] now, input logic [31:0] start);
    logic [31:0] diff;
    diff = now - start;
    return ~diff[31];
  endfunction

endpackage

// File: rtl/cmd_timebase.sv
// -----------------------------------------------------------------------------
// cmd_timebase
//   Free-running 32-bit timebase with a clock prescaler.
//   The counter advances once every TIME_PRESCALE clock cycles and wraps.
//   A synchronous clear zeroes both the prescaler and the counter and takes
//   priority over that cycle's increment.
//
//   Ports:
//     clk      in   system clock
//     rst      in   synchronous active-high reset
//     i_clear  in   synchronous clear of prescaler and counter
//     o_time   out  current timebase value
// -----------------------------------------------------------------------------
module cmd_timebase #(
  parameter int unsigned TIME_PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  output logic [31:0] o_time
);

  // A prescale below 1 is treated as 1.
  localparam int unsigned PsDiv = (TIME_PRESCALE > 1) ? TIME_PRESCALE : 1;
  localparam int unsigned PsW   = (PsDiv > 1) ? $clog2(PsDiv) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(PsDiv - 1);

  logic [PsW-1:0] r_ps;
  logic [31:0]    r_time;
  logic           w_tick;

  assign w_tick = (r_ps == PsLast);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_ps   <= '0;
      r_time <= '0;
    end else if (w_tick) begin
      r_ps   <= '0;
      r_time <= r_time + 32'd1;
    end else begin
      r_ps   <= r_ps + PsW'(1);
    end
  end

  assign o_time = r_time;

endmodule

// File: rtl/cmd_dispatcher.sv
// -----------------------------------------------------------------------------
// cmd_dispatcher
//   Consumer of the 80-bit EBI command FIFO. Pops one command, holds it until
//   its start_time on the local timebase, then either executes it locally
//   (addr 0xFF) or presents it to the pin-controller bus with req/ack.
//   A request left unacknowledged for ACK_TIMEOUT cycles is dropped and
//   reported with a one-cycle cmd_timeout pulse.
//
//   Ports:
//     clk                in   system clock
//     rst                in   synchronous active-high reset
//     cmd_fifo_data_out  in   command word, valid the cycle after rd_en
//     cmd_fifo_empty     in   FIFO empty flag
//     cmd_fifo_rd_en     out  single-cycle FIFO pop
//     bus_addr           out  target controller id
//     bus_op             out  opcode
//     bus_data           out  payload
//     bus_req            out  request, held until ack or timeout
//     bus_ack            in   target acceptance
//     current_time       out  timebase value
//     busy               out  FSM not idle
//     cmd_timeout        out  one-cycle pulse when a command is dropped
// -----------------------------------------------------------------------------
module cmd_dispatcher
  import cmd_dispatcher_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT   = 255,
  parameter int unsigned TIME_PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] cmd_fifo_data_out,
  input  logic             cmd_fifo_empty,
  output logic             cmd_fifo_rd_en,
  output logic [7:0]       bus_addr,
  output logic [7:0]       bus_op,
  output logic [31:0]      bus_data,
  output logic             bus_req,
  input  logic             bus_ack,
  output logic [31:0]      current_time,
  output logic             busy,
  output logic             cmd_timeout
);

  // Timeout counter only has to reach ACK_TIMEOUT-1; a zero timeout acts as 1.
  localparam int unsigned AckMax = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT : 1;
  localparam int unsigned ToW    = (AckMax > 1) ? $clog2(AckMax) : 1;
  localparam logic [ToW-1:0] ToLast = ToW'(AckMax - 1);

  disp_state_e      r_state;
  logic [CMD_W-1:0] r_cmd;
  logic [ToW-1:0]   r_to_cnt;
  logic             r_bus_req;
  logic             r_timeout;
  logic [7:0]       r_bus_addr;
  logic [7:0]       r_bus_op;
  logic [31:0]      r_bus_data;

  logic [7:0]       w_addr;
  logic [7:0]       w_op;
  logic [31:0]      w_start;
  logic [31:0]      w_data;
  logic [31:0]      w_time;
  logic             w_due;
  logic             w_is_local;
  logic             w_time_clear;

  assign w_addr  = r_cmd[ADDR_HI:ADDR_LO];
  assign w_op    = r_cmd[OP_HI:OP_LO];
  assign w_start = r_cmd[TIME_HI:TIME_LO];
  assign w_data  = r_cmd[DATA_HI:DATA_LO];

  assign w_due      = time_due(w_time, w_start);
  assign w_is_local = (w_addr == LOCAL_ADDR);

  // Local time reset executes on the edge that leaves WAIT_TIME.
  assign w_time_clear = (r_state == StWaitTime) && w_due && w_is_local &&
                        (w_op == OP_RESET_TIME);

  cmd_timebase #(
    .TIME_PRESCALE (TIME_PRESCALE)
  ) u_timebase (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_time_clear),
    .o_time  (w_time)
  );

  // Combinational pop so the word is on the FIFO output during LATCH.
  assign cmd_fifo_rd_en = !rst && (r_state == StIdle) && !cmd_fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cmd      <= '0;
      r_to_cnt   <= '0;
      r_bus_req  <= 1'b0;
      r_timeout  <= 1'b0;
      r_bus_addr <= '0;
      r_bus_op   <= '0;
      r_bus_data <= '0;
    end else begin
      r_timeout <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (!cmd_fifo_empty) begin
            r_state <= StLatch;
          end
        end
        StLatch: begin
          r_cmd   <= cmd_fifo_data_out;
          r_state <= StWaitTime;
        end
        StWaitTime: begin
          if (w_due) begin
            if (w_is_local) begin
              // Reset-time is applied via w_time_clear; other local ops are NOPs.
              r_state <= StIdle;
            end else begin
              r_bus_addr <= w_addr;
              r_bus_op   <= w_op;
              r_bus_data <= w_data;
              r_bus_req  <= 1'b1;
              r_to_cnt   <= '0;
              r_state    <= StWaitAck;
            end
          end
        end
        StWaitAck: begin
          // Ack is checked first so it wins over a same-cycle timeout.
          if (bus_ack) begin
            r_bus_req <= 1'b0;
            r_state   <= StIdle;
          end else if (r_to_cnt == ToLast) begin
            r_bus_req <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= StIdle;
          end else begin
            r_to_cnt <= r_to_cnt + ToW'(1);
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus_addr     = r_bus_addr;
  assign bus_op       = r_bus_op;
  assign bus_data     = r_bus_data;
  assign bus_req      = r_bus_req;
  assign cmd_timeout  = r_timeout;
  assign busy         = (r_state != StIdle);
  assign current_time = w_time;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_cmd_dispatcher
//   Self-checking bench: a non-FWFT FIFO model driven from the test thread,
//   a table of single-command vectors, and hand-written multi-cycle sequences.
//   Inputs change and outputs are sampled at the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cmd_dispatcher;

  localparam int unsigned AckTo = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] cmd_fifo_data_out;
  logic        cmd_fifo_empty;
  logic        cmd_fifo_rd_en;
  logic [7:0]  bus_addr;
  logic [7:0]  bus_op;
  logic [31:0] bus_data;
  logic        bus_req;
  logic        bus_ack;
  logic [31:0] current_time;
  logic        busy;
  logic        cmd_timeout;

  cmd_dispatcher #(
    .ACK_TIMEOUT   (AckTo),
    .TIME_PRESCALE (1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_fifo_data_out (cmd_fifo_data_out),
    .cmd_fifo_empty    (cmd_fifo_empty),
    .cmd_fifo_rd_en    (cmd_fifo_rd_en),
    .bus_addr          (bus_addr),
    .bus_op            (bus_op),
    .bus_data          (bus_data),
    .bus_req           (bus_req),
    .bus_ack           (bus_ack),
    .current_time      (current_time),
    .busy              (busy),
    .cmd_timeout       (cmd_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] word;
    int          ack_delay;  // WAIT_ACK cycle index at which ack is driven; 99 = never
    bit          exp_issue;
    bit          exp_to;
    int          exp_hi;     // cycles bus_req is expected high
  } vec_t;

  vec_t        vecs[6];
  logic [79:0] q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          underflow = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [79:0] w);
    q.push_back(w);
    cmd_fifo_empty = 1'b0;
    #1;
  endtask

  // One clock: pops the model FIFO if rd_en was high before the edge, then
  // returns at the next falling edge.
  task automatic step();
    logic pop;
    pop = cmd_fifo_rd_en;
    @(posedge clk);
    #1;
    if (pop) begin
      if (q.size() == 0) underflow++;
      else cmd_fifo_data_out = q.pop_front();
    end
    cmd_fifo_empty = (q.size() == 0);
    @(negedge clk);
  endtask

  initial begin
    int          hi;
    int          t0;
    int          found;
    logic [31:0] prev_time;
    logic [79:0] w;

    vecs[0] = '{{8'h03, 8'h02, 32'h0, 32'hDEAD_BEEF}, 0,  1'b1, 1'b0, 1};
    vecs[1] = '{{8'h10, 8'hA5, 32'h0, 32'h1234_5678}, 3,  1'b1, 1'b0, 4};
    // Ack arrives on the last cycle before timeout: ack must win.
    vecs[2] = '{{8'hFE, 8'hFF, 32'h0, 32'h0000_FFFF}, 7,  1'b1, 1'b0, 8};
    vecs[3] = '{{8'hFF, 8'h07, 32'h0, 32'h5555_AAAA}, 0,  1'b0, 1'b0, 0};
    vecs[4] = '{{8'h22, 8'h33, 32'h0, 32'hCAFE_F00D}, 99, 1'b1, 1'b1, 8};
    // start_time just "behind" zero: already due thanks to wrap-safe compare.
    vecs[5] = '{{8'h01, 8'h00, 32'hFFFF_FFF0, 32'h0000_0001}, 0, 1'b1, 1'b0, 1};

    rst = 1'b1;
    bus_ack = 1'b0;
    cmd_fifo_empty = 1'b1;
    cmd_fifo_data_out = '0;
    @(negedge clk);
    step();
    step();

    // Reset state
    chk("rst_rd_en", cmd_fifo_rd_en, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_time", current_time, 0);
    chk("rst_timeout", cmd_timeout, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_op", bus_op, 0);
    chk("rst_data", bus_data, 0);
    rst = 1'b0;

    // Latency with ack tied high
    bus_ack = 1'b1;
    push({8'h03, 8'h02, 32'h0, 32'hDEAD_BEEF});
    chk("lat_c0_rd_en", cmd_fifo_rd_en, 1);
    step();
    chk("lat_c1_rd_en", cmd_fifo_rd_en, 0);
    chk("lat_c1_busy", busy, 1);
    step();
    chk("lat_c2_req", bus_req, 0);
    step();
    chk("lat_c3_req", bus_req, 1);
    chk("lat_c3_addr", bus_addr, 32'h03);
    chk("lat_c3_op", bus_op, 32'h02);
    chk("lat_c3_data", bus_data, 32'hDEAD_BEEF);
    step();
    chk("lat_c4_req", bus_req, 0);
    chk("lat_c4_busy", busy, 0);

    // Local time reset once the timebase has passed 500
    for (int i = 0; i < 1000 && current_time < 500; i++) step();
    chk("tr_reached_500", (current_time >= 500), 1);
    t0 = current_time;
    push({8'hFF, 8'h01, 32'h0, 32'h0});
    found = 0;
    step();
    found += bus_req;
    step();
    found += bus_req;
    chk("tr_c2_time", current_time, t0 + 2);
    step();
    found += bus_req;
    chk("tr_c3_time", current_time, 0);
    chk("tr_c3_busy", busy, 0);
    chk("tr_no_req", found, 0);

    // Scheduled start at 1000; the decision is taken in the tick where
    // current_time == 1000 and bus_req is high from the following cycle.
    push({8'h04, 8'h11, 32'd1000, 32'h0BAD_F00D});
    found = 0;
    prev_time = current_time;
    for (int i = 0; i < 1200; i++) begin
      prev_time = current_time;
      step();
      if (bus_req) begin
        found = 1;
        break;
      end
    end
    chk("sched_found", found, 1);
    chk("sched_eval_time", prev_time, 1000);
    chk("sched_addr", bus_addr, 32'h04);
    step();
    chk("sched_req_drop", bus_req, 0);

    // start_time = 5 is in the past: issues with minimum latency
    push({8'h05, 8'h09, 32'd5, 32'h0000_0055});
    step();
    step();
    chk("imm_c2_req", bus_req, 0);
    step();
    chk("imm_c3_req", bus_req, 1);
    chk("imm_c3_data", bus_data, 32'h0000_0055);
    step();
    bus_ack = 1'b0;

    // Table-driven single commands
    foreach (vecs[i]) begin
      w = vecs[i].word;
      push(w);
      chk($sformatf("v%0d_rd_en", i), cmd_fifo_rd_en, 1);
      step();
      step();
      chk($sformatf("v%0d_c2_req", i), bus_req, 0);
      step();
      chk($sformatf("v%0d_issue", i), bus_req, vecs[i].exp_issue);
      if (vecs[i].exp_issue) begin
        chk($sformatf("v%0d_addr", i), bus_addr, w[79:72]);
        chk($sformatf("v%0d_op", i), bus_op, w[71:64]);
        chk($sformatf("v%0d_data", i), bus_data, w[31:0]);
        hi = 0;
        for (int k = 0; k < 20 && bus_req; k++) begin
          hi++;
          bus_ack = (k == vecs[i].ack_delay);
          step();
        end
        bus_ack = 1'b0;
        chk($sformatf("v%0d_req_cycles", i), hi, vecs[i].exp_hi);
        chk($sformatf("v%0d_timeout", i), cmd_timeout, vecs[i].exp_to);
        chk($sformatf("v%0d_busy_end", i), busy, 0);
        step();
        chk($sformatf("v%0d_timeout_clr", i), cmd_timeout, 0);
      end else begin
        chk($sformatf("v%0d_busy_end", i), busy, 0);
        chk($sformatf("v%0d_timeout", i), cmd_timeout, 0);
      end
    end

    // Timeout with a second command queued behind it
    bus_ack = 1'b0;
    push({8'h22, 8'h33, 32'h0, 32'h1111_1111});
    push({8'h23, 8'h44, 32'h0, 32'h2222_2222});
    step();
    step();
    step();
    chk("to_c3_req", bus_req, 1);
    hi = 0;
    for (int k = 0; k < 20 && bus_req; k++) begin
      hi++;
      step();
    end
    chk("to_req_cycles", hi, AckTo);
    chk("to_pulse", cmd_timeout, 1);
    chk("to_next_pop", cmd_fifo_rd_en, 1);
    step();
    chk("to_pulse_one_cycle", cmd_timeout, 0);
    chk("to_next_busy", busy, 1);
    step();
    step();
    bus_ack = 1'b1;
    chk("to_next_req", bus_req, 1);
    chk("to_next_addr", bus_addr, 32'h23);
    chk("to_next_data", bus_data, 32'h2222_2222);
    step();
    chk("to_next_done", bus_req, 0);
    bus_ack = 1'b0;

    // Reset in the middle of a handshake
    push({8'h05, 8'h06, 32'h0, 32'h0000_0001});
    step();
    step();
    step();
    chk("mid_req_before", bus_req, 1);
    rst = 1'b1;
    step();
    chk("mid_req", bus_req, 0);
    chk("mid_busy", busy, 0);
    chk("mid_time", current_time, 0);
    chk("mid_rd_en", cmd_fifo_rd_en, 0);
    chk("mid_timeout", cmd_timeout, 0);
    rst = 1'b0;
    step();
    chk("mid_after_busy", busy, 0);

    chk("fifo_underflow", underflow, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
